call_button_conditioner: RTL and testbench

- Input stage that sits directly upstream of the elevator top level and drives its button_out and button_in vectors.
- Takes raw, asynchronous, bouncing push-button levels from the hall panels (outside the car) and the car panel (inside).
- For each button it synchronises, debounces and edge-detects the signal, then issues one single-cycle press pulse per physical press.
- It also suppresses presses for the floor where the car already stands with the door open, and flags buttons stuck high.

---
 rtl/elevator_pkg.sv | 11 +
 rtl/button_debounce.sv | 83 ++++++++
 rtl/call_button_conditioner.sv | 70 +++++++
 tb/tb_call_button_conditioner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Default sizing constants shared by the elevator top level and its input stage.
// Both blocks size their per-floor vectors from ELEV_N.
package elevator_pkg;

    localparam int ELEV_N        = 10;
    localparam int ELEV_DEBOUNCE = 4;
    localparam int ELEV_DB_W     = 3;
    localparam int ELEV_STUCK    = 200;
    localparam int ELEV_ST_W     = 8;

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: 2-flop synchroniser, counter debounce, rising-edge
// detect and a saturating held-too-long (stuck) detector.
module button_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE = ELEV_DEBOUNCE,
    parameter int DB_W     = ELEV_DB_W,
    parameter int STUCK    = ELEV_STUCK,
    parameter int ST_W     = ELEV_ST_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic stuck
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [ST_W-1:0] ST_LIM  = ST_W'(STUCK);

    logic            m_r;
    logic            s_r;
    logic            st_r;
    logic            st_next_s;
    logic [DB_W-1:0] cnt_r;
    logic [DB_W-1:0] cnt_next_s;
    logic [ST_W-1:0] sc_r;
    logic [ST_W-1:0] sc_next_s;
    logic            stuck_r;
    logic            stuck_next_s;

    // Debounce: a new level is accepted only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        st_next_s  = st_r;
        cnt_next_s = cnt_r;
        if (s_r == st_r) begin
            cnt_next_s = {DB_W{1'b0}};
        end else if (cnt_r == DB_LAST) begin
            st_next_s  = s_r;
            cnt_next_s = {DB_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + DB_W'(1);
        end
    end

    // Stuck counter saturates at STUCK; the flag holds until the stable level drops.
    always_comb begin
        sc_next_s    = sc_r;
        stuck_next_s = stuck_r;
        if (!st_r) begin
            sc_next_s    = {ST_W{1'b0}};
            stuck_next_s = 1'b0;
        end else if (sc_r != ST_LIM) begin
            sc_next_s = sc_r + ST_W'(1);
        end else begin
            stuck_next_s = 1'b1;
        end
    end

    // Channel state registers, including the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r     <= 1'b0;
            s_r     <= 1'b0;
            st_r    <= 1'b0;
            cnt_r   <= {DB_W{1'b0}};
            sc_r    <= {ST_W{1'b0}};
            stuck_r <= 1'b0;
        end else begin
            m_r     <= raw;
            s_r     <= m_r;
            st_r    <= st_next_s;
            cnt_r   <= cnt_next_s;
            sc_r    <= sc_next_s;
            stuck_r <= stuck_next_s;
        end
    end

    // Rising edge of the stable level; the parent registers it after masking.
    assign pulse = st_next_s & ~st_r;
    assign stuck = stuck_r;

endmodule

// File: rtl/call_button_conditioner.sv
// Conditions raw hall and car call buttons into single-cycle press pulses,
// dropping presses for the floor where the car stands with its door open.
module call_button_conditioner
    import elevator_pkg::*;
#(
    parameter int n        = ELEV_N,
    parameter int DEBOUNCE = ELEV_DEBOUNCE,
    parameter int DB_W     = ELEV_DB_W,
    parameter int STUCK    = ELEV_STUCK,
    parameter int ST_W     = ELEV_ST_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] raw_out,
    input  logic [n-1:0] raw_in,
    input  logic [n-1:0] current_floor,
    input  logic         open,
    output logic [n-1:0] button_out,
    output logic [n-1:0] button_in,
    output logic [n-1:0] stuck_out,
    output logic [n-1:0] stuck_in
);

    logic [n-1:0] pulse_out_s;
    logic [n-1:0] pulse_in_s;
    logic [n-1:0] supp_s;

    for (genvar k = 0; k < n; k++) begin : g_chan
        button_debounce #(
            .DEBOUNCE (DEBOUNCE),
            .DB_W     (DB_W),
            .STUCK    (STUCK),
            .ST_W     (ST_W)
        ) u_hall (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_out[k]),
            .pulse (pulse_out_s[k]),
            .stuck (stuck_out[k])
        );

        button_debounce #(
            .DEBOUNCE (DEBOUNCE),
            .DB_W     (DB_W),
            .STUCK    (STUCK),
            .ST_W     (ST_W)
        ) u_car (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_in[k]),
            .pulse (pulse_in_s[k]),
            .stuck (stuck_in[k])
        );
    end

    // A press at the open-door floor is already served, so it is discarded rather than held.
    assign supp_s = current_floor & {n{open}};

    // Registered, masked press pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_out <= {n{1'b0}};
            button_in  <= {n{1'b0}};
        end else begin
            button_out <= pulse_out_s & ~supp_s;
            button_in  <= pulse_in_s & ~supp_s;
        end
    end

endmodule

// File: tb/tb_call_button_conditioner.sv
// Directed bench for call_button_conditioner with n=4, DEBOUNCE=4, STUCK=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_call_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_out;
    logic [3:0] raw_in;
    logic [3:0] current_floor;
    logic       open;
    logic [3:0] button_out;
    logic [3:0] button_in;
    logic [3:0] stuck_out;
    logic [3:0] stuck_in;

    int n_assert;
    int n_fail;
    int pout_cnt [4];
    int pin_cnt  [4];
    int s_all;
    int s_one;
    int k;

    call_button_conditioner #(
        .n        (4),
        .DEBOUNCE (4),
        .DB_W     (3),
        .STUCK    (20),
        .ST_W     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_out       (raw_out),
        .raw_in        (raw_in),
        .current_floor (current_floor),
        .open          (open),
        .button_out    (button_out),
        .button_in     (button_in),
        .stuck_out     (stuck_out),
        .stuck_in      (stuck_in)
    );

    always #5 clk = ~clk;

    // Running per-bit pulse totals, sampled mid-cycle.
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (button_out[b]) pout_cnt[b] = pout_cnt[b] + 1;
            if (button_in[b])  pin_cnt[b]  = pin_cnt[b] + 1;
        end
    end

    function automatic int total_pulses();
        int t;
        t = 0;
        for (int b = 0; b < 4; b++) t = t + pout_cnt[b] + pin_cnt[b];
        return t;
    endfunction

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        raw_out       = 4'b0000;
        raw_in        = 4'b0000;
        current_floor = 4'b0001;
        open          = 1'b0;

        tick(3);
        chk("reset_outputs", {button_out, button_in, stuck_out, stuck_in}, 16'h0000);
        rst_n = 1'b1;
        tick(2);

        // Clean press on car button 2
        s_all  = total_pulses();
        raw_in = 4'b0100;
        tick(5);
        chk("t1_no_early_pulse", button_in, 4'b0000);
        tick(1);
        chk("t1_pulse_in", button_in, 4'b0100);
        chk("t1_out_quiet", button_out, 4'b0000);
        tick(1);
        chk("t1_single_cycle", button_in, 4'b0000);
        tick(19);
        chk("t1_stuck_not_yet", stuck_in, 4'b0000);
        tick(1);
        chk("t1_stuck_set", stuck_in, 4'b0100);
        tick(3);
        chk("t1_one_pulse_total", total_pulses() - s_all, 32'd1);
        raw_in = 4'b0000;
        tick(8);
        chk("t1_stuck_cleared", stuck_in, 4'b0000);
        chk("t1_no_release_pulse", total_pulses() - s_all, 32'd1);

        // 3-cycle glitch, then bounce on hall button 1
        s_all   = total_pulses();
        raw_out = 4'b1000;
        tick(3);
        raw_out = 4'b0000;
        tick(12);
        chk("t2_glitch3_no_pulse", total_pulses() - s_all, 32'd0);
        raw_out = 4'b0010; tick(1);
        raw_out = 4'b0000; tick(1);
        raw_out = 4'b0010; tick(1);
        raw_out = 4'b0000; tick(1);
        raw_out = 4'b0010;
        tick(5);
        chk("t2_bounce_no_early", total_pulses() - s_all, 32'd0);
        tick(1);
        chk("t2_bounce_pulse", button_out, 4'b0010);
        tick(8);
        chk("t2_one_pulse_total", total_pulses() - s_all, 32'd1);
        raw_out = 4'b0000;
        tick(8);

        // Suppression at floor 0 with the door open, then the same press with it closed
        s_all         = total_pulses();
        current_floor = 4'b0001;
        open          = 1'b1;
        raw_out       = 4'b0001;
        raw_in        = 4'b0001;
        tick(6);
        chk("t3_supp_out", button_out, 4'b0000);
        chk("t3_supp_in", button_in, 4'b0000);
        tick(4);
        chk("t3_supp_none", total_pulses() - s_all, 32'd0);
        raw_out = 4'b0000;
        raw_in  = 4'b0000;
        tick(8);
        open    = 1'b0;
        raw_out = 4'b0001;
        raw_in  = 4'b0001;
        tick(6);
        chk("t3_open0_out", button_out, 4'b0001);
        chk("t3_open0_in", button_in, 4'b0001);
        raw_out = 4'b0000;
        raw_in  = 4'b0000;
        tick(8);
        chk("t3_two_pulses", total_pulses() - s_all, 32'd2);

        // Simultaneous presses
        raw_out = 4'b1001;
        raw_in  = 4'b0110;
        tick(6);
        chk("t4_sim_out", button_out, 4'b1001);
        chk("t4_sim_in", button_in, 4'b0110);
        tick(1);
        chk("t4_sim_after", {button_out, button_in}, 8'h00);
        raw_out = 4'b0000;
        raw_in  = 4'b0000;
        tick(8);

        // Reset mid-press; hall 2 is pulsing and car 3 is two counts into debounce
        raw_out = 4'b0100;
        tick(2);
        raw_in = 4'b1000;
        tick(4);
        chk("t5_pulse_before_reset", button_out, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", {button_out, button_in, stuck_out, stuck_in}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        chk("t5_no_early", {button_out, button_in}, 8'h00);
        tick(1);
        chk("t5_repress_in", button_in, 4'b1000);
        chk("t5_repress_out", button_out, 4'b0100);
        raw_out = 4'b0000;
        raw_in  = 4'b0000;
        tick(8);

        // Stuck set and clear on car button 1
        s_one  = pin_cnt[1];
        raw_in = 4'b0010;
        k      = 0;
        while (stuck_in[1] !== 1'b1 && k < 40) begin
            tick(1);
            k = k + 1;
        end
        chk("t6_stuck_latency", k, 32'd27);
        raw_in = 4'b0000;
        tick(6);
        chk("t6_stuck_held_at_fall", stuck_in, 4'b0010);
        tick(1);
        chk("t6_stuck_cleared", stuck_in, 4'b0000);
        tick(4);
        chk("t6_one_pulse_no_release", pin_cnt[1] - s_one, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
